// File: rtl/jtframe_linescroll.sv
// Per-line horizontal scroll: fetches a table word on hs rise and commits scrx on hs fall; 4-cycle minimum latency.
// Memory stalls are absorbed by holding ram_cs/ram_addr until ram_ok; a fetch that misses its commit point raises late.
module jtframe_linescroll #(
    parameter int AW = 10,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hs,
    input  logic          vs,
    input  logic [LW-1:0] vdump,
    input  logic          flip,
    input  logic          en,
    input  logic [8:0]    gscrx,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] ram_addr,
    output logic          ram_cs,
    input  logic [15:0]   ram_data,
    input  logic          ram_ok,
    output logic [8:0]    scrx,
    output logic          late
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          hsl_q, vsl_q;
    logic          first_q, first_d;
    logic          missed_q, missed_d;
    logic          done_q, done_d;
    logic [8:0]    pending_q, pending_d;
    logic [9:0]    data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cs_q, cs_d;
    logic [8:0]    scrx_q, scrx_d;
    logic          late_q, late_d;

    logic          hs_rise, hs_fall, vs_rise;
    logic [LW-1:0] line_nxt, idx;
    logic [AW-1:0] fetch_addr;
    logic [8:0]    calc;
    logic          overrun, start, late_set;
    logic          unused_data;

    assign hs_rise = hs & ~hsl_q;
    assign hs_fall = ~hs & hsl_q;
    assign vs_rise = vs & ~vsl_q;

    // The table is indexed by the line about to be drawn, mirrored when flipped.
    assign line_nxt   = vdump + 1'b1;
    assign idx        = flip ? ~line_nxt : line_nxt;
    assign fetch_addr = base + AW'(idx);

    assign calc        = data_q[9] ? data_q[8:0] : gscrx + data_q[8:0];
    assign overrun     = hs_rise && (state_q != ST_IDLE);
    assign unused_data = ^ram_data[14:9];

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        missed_d  = missed_q;
        done_d    = done_q;
        pending_d = pending_q;
        data_d    = data_q;
        addr_d    = addr_q;
        cs_d      = cs_q;
        scrx_d    = scrx_q;
        late_set  = 1'b0;
        start     = 1'b0;

        if (hs_fall) begin
            done_d = 1'b0;
            if (!en) begin
                scrx_d = gscrx;
            end else if (done_q) begin
                scrx_d = pending_q;
            end else begin
                late_set = 1'b1;
                missed_d = 1'b1;
            end
        end

        if (overrun) begin
            late_set = 1'b1;
            if (en) begin
                start = 1'b1;
            end else begin
                cs_d    = 1'b0;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: start = hs_rise && en;
                ST_WAIT: begin
                    // ram_ok in the first request cycle may belong to an aborted fetch
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (ram_ok) begin
                        data_d  = {ram_data[15], ram_data[8:0]};
                        cs_d    = 1'b0;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    state_d   = ST_IDLE;
                    pending_d = calc;
                    if (missed_d) begin
                        scrx_d = calc;
                    end else if (!hs_fall) begin
                        done_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start) begin
            addr_d   = fetch_addr;
            cs_d     = 1'b1;
            first_d  = 1'b1;
            missed_d = 1'b0;
            state_d  = ST_WAIT;
        end

        if (late_set) begin
            late_d = 1'b1;
        end else if (vs_rise) begin
            late_d = 1'b0;
        end else begin
            late_d = late_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hsl_q     <= 1'b0;
            vsl_q     <= 1'b0;
            first_q   <= 1'b0;
            missed_q  <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            scrx_q    <= '0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hsl_q     <= hs;
            vsl_q     <= vs;
            first_q   <= first_d;
            missed_q  <= missed_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            scrx_q    <= scrx_d;
            late_q    <= late_d;
        end
    end

    assign ram_addr = addr_q;
    assign ram_cs   = cs_q;
    assign scrx     = scrx_q;
    assign late     = late_q;

endmodule

// File: tb/tb_jtframe_linescroll.sv
// Bench for jtframe_linescroll: randomized lines scored against a line-level model via queues.
module tb_jtframe_linescroll;
    localparam int AW = 10;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs = 1'b0;
    logic          vs = 1'b0;
    logic [LW-1:0] vdump = '0;
    logic          flip = 1'b0;
    logic          en = 1'b0;
    logic [8:0]    gscrx = '0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic [15:0]   ram_data = '0;
    logic          ram_ok = 1'b0;
    logic [8:0]    scrx;
    logic          late;

    jtframe_linescroll #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .vdump(vdump),
        .flip(flip), .en(en), .gscrx(gscrx), .base(base),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_data(ram_data),
        .ram_ok(ram_ok), .scrx(scrx), .late(late)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Table memory: ram_ok comes lat_cfg cycles after a request (re)starts
    logic [15:0]   mem [0:1023];
    int            lat_cfg = 1000;
    int            rsp_cnt = 0;
    logic          rsp_cs_prev = 1'b0;
    logic [AW-1:0] rsp_addr_prev = '0;

    always @(posedge clk) begin
        #1;
        if (ram_cs) begin
            if (!rsp_cs_prev || ram_addr != rsp_addr_prev) rsp_cnt = 0;
            else rsp_cnt++;
            ram_ok   = (rsp_cnt >= lat_cfg);
            ram_data = mem[ram_addr];
        end else begin
            ram_ok  = 1'b0;
            rsp_cnt = 0;
        end
        rsp_cs_prev   = ram_cs;
        rsp_addr_prev = ram_addr;
    end

    // Scoreboard
    int    addr_q[$];
    int    exp_scrx_q[$];
    int    exp_late_q[$];
    string exp_name_q[$];
    logic  chk_stb = 1'b0;

    int            cs_len = 0, last_cs_len = 0, cs_rises = 0, cs_falls = 0;
    logic          mon_cs_prev = 1'b0;
    logic [AW-1:0] mon_addr_prev = '0;
    string         mon_nm;
    int            mon_es, mon_el;

    always @(negedge clk) begin
        if (chk_stb) begin
            if (exp_scrx_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                mon_nm = exp_name_q.pop_front();
                mon_es = exp_scrx_q.pop_front();
                mon_el = exp_late_q.pop_front();
                check({mon_nm, "_scrx"}, int'(scrx), mon_es);
                check({mon_nm, "_late"}, int'(late), mon_el);
            end
        end
        if (ram_cs && (!mon_cs_prev || ram_addr != mon_addr_prev)) begin
            if (!mon_cs_prev) cs_rises++;
            if (addr_q.size() == 0) check("unexpected_fetch", int'(ram_addr), -1);
            else check("ram_addr", int'(ram_addr), addr_q.pop_front());
        end
        if (ram_cs) begin
            cs_len++;
        end else if (mon_cs_prev) begin
            last_cs_len = cs_len;
            cs_len = 0;
            cs_falls++;
        end
        mon_cs_prev   = ram_cs;
        mon_addr_prev = ram_addr;
    end

    // Reference model
    int scrx_m = 0;
    int late_m = 0;

    function automatic int maddr(input int vd);
        int idx;
        idx = (vd + 1) % 512;
        if (flip) idx = 511 - idx;
        return (int'(base) + idx) % 1024;
    endfunction

    function automatic int pend(input int d, input int gs);
        if (d >= 32768) return d % 512;
        return (gs + d % 512) % 512;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string nm, input int s, input int l);
        exp_name_q.push_back(nm);
        exp_scrx_q.push_back(s);
        exp_late_q.push_back(l);
        chk_stb = 1'b1;
        tick(1);
        chk_stb = 1'b0;
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(1);
        late_m = 0;
    endtask

    // One line: hs high for w cycles, memory answers lat cycles after the request
    task automatic run_line(input bit e, input int vd, input int gs, input int lat, input int w);
        int  a, p, c;
        bit  ontime;
        en      = e;
        vdump   = LW'(vd);
        gscrx   = 9'(gs);
        lat_cfg = lat;
        a = maddr(vd);
        p = pend(int'(mem[a]), gs);
        c = (lat + 1 > 2) ? lat + 1 : 2;
        ontime = (w >= c + 2);
        if (e) addr_q.push_back(a);
        hs = 1'b1;
        tick(w);
        hs = 1'b0;
        if (e && lat >= w) begin
            tick(1);
            expect_now("hold", scrx_m, 1);
        end
        tick(lat + 8);
        if (!e) begin
            scrx_m = gs;
        end else begin
            scrx_m = p;
            if (!ontime) late_m = 1;
        end
        expect_now("line", scrx_m, late_m);
    endtask

    int f0, r0, a2;
    bit re;
    int rlat, rw;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        tick(3);
        check("reset_scrx", int'(scrx), 0);
        check("reset_cs", int'(ram_cs), 0);
        check("reset_addr", int'(ram_addr), 0);
        check("reset_late", int'(late), 0);
        rst_n = 1'b1;
        tick(2);

        // Basic offset
        base = 10'h100;
        mem[10'h10A] = 16'h0005;
        run_line(1'b1, 9, 9'h010, 2, 8);
        check("basic_scrx_const", scrx_m, 9'h015);
        check("basic_cs_len", last_cs_len, 3);

        // Absolute and 9-bit wrap
        mem[maddr(20)] = 16'h8123;
        run_line(1'b1, 20, 9'h0F0, 2, 8);
        mem[maddr(21)] = 16'h01F0;
        run_line(1'b1, 21, 9'h020, 1, 6);

        // Flip with address wrap
        flip = 1'b1;
        base = 10'h3FF;
        run_line(1'b1, 0, 9'h011, 1, 7);
        flip = 1'b0;
        base = 10'h100;

        // Slow memory: ram_ok 10 cycles after hs fall
        run_line(1'b1, 30, 9'h040, 17, 8);
        vs_pulse();
        expect_now("vs_clear", scrx_m, 0);

        // Overrun: first fetch never answered, second hs rise restarts it
        en = 1'b1; vdump = 9'd40; gscrx = 9'h055; lat_cfg = 1000;
        mem[maddr(41)] = 16'h8155;
        addr_q.push_back(maddr(40));
        hs = 1'b1; tick(4); hs = 1'b0; tick(3);
        vs_pulse();
        expect_now("pre_overrun", scrx_m, 0);
        f0 = cs_falls;
        vdump = 9'd41;
        a2 = maddr(41);
        addr_q.push_back(a2);
        hs = 1'b1; tick(1); lat_cfg = 2; tick(1);
        check("overrun_cs_high", int'(ram_cs), 1);
        check("overrun_no_drop", cs_falls - f0, 0);
        check("overrun_late", int'(late), 1);
        tick(6); hs = 1'b0; tick(10);
        scrx_m = pend(int'(mem[a2]), 9'h055);
        late_m = 1;
        expect_now("overrun_line", scrx_m, late_m);

        // Asynchronous reset in the middle of a fetch
        vdump = 9'd60; lat_cfg = 1000;
        addr_q.push_back(maddr(60));
        hs = 1'b1; tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs", int'(ram_cs), 0);
        check("rst_scrx", int'(scrx), 0);
        check("rst_late", int'(late), 0);
        check("rst_addr", int'(ram_addr), 0);
        hs = 1'b0;
        tick(2);
        rst_n = 1'b1;
        scrx_m = 0; late_m = 0;
        tick(2);
        expect_now("post_reset", scrx_m, late_m);

        // Disabled
        r0 = cs_rises;
        run_line(1'b0, 70, 9'h0AA, 2, 6);
        check("dis_no_cs", cs_rises - r0, 0);

        // en drops while the fetch is in flight
        en = 1'b1; vdump = 9'd80; gscrx = 9'h033; lat_cfg = 1;
        addr_q.push_back(maddr(80));
        hs = 1'b1; tick(2); en = 1'b0; tick(6); hs = 1'b0; tick(8);
        scrx_m = 9'h033;
        expect_now("en_drop", scrx_m, late_m);

        // Randomized lines
        for (int i = 0; i < 40; i++) begin
            flip = 1'($urandom_range(0, 1));
            base = AW'($urandom_range(0, 1023));
            re   = ($urandom_range(0, 3) != 0);
            rw   = $urandom_range(3, 9);
            rlat = ($urandom_range(0, 4) == 0) ? $urandom_range(rw, rw + 8) : $urandom_range(0, 3);
            run_line(re, $urandom_range(0, 511), $urandom_range(0, 511), rlat, rw);
            if ($urandom_range(0, 3) == 0) vs_pulse();
        end

        tick(5);
        check("fetch_queue_drained", addr_q.size(), 0);
        check("scoreboard_drained", exp_scrx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

endmodule
